// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared widths and state encoding for the RSA reduction datapath
package rsa_pkg;

  localparam int PROD_W = 128;
  localparam int MOD_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } red_state_t;

endpackage

// File: rtl/mod_reduce_seq_cond_sub.sv
// rtl/mod_reduce_seq_cond_sub.sv - combinational compare-and-subtract step of restoring reduction
module cond_sub #(
  parameter int W = rsa_pkg::MOD_W + 1
) (
  input  logic [W-1:0] t,
  input  logic [W-1:0] m,
  output logic [W-2:0] t_next
);

  // The caller keeps t < 2*m, so the remainder always fits in W-1 bits and
  // the dropped top bit of the difference is known to be zero.
  assign t_next = (t >= m) ? (W-1)'(t - m) : t[W-2:0];

endmodule

// File: rtl/mod_reduce_seq.sv
// rtl/mod_reduce_seq.sv - bit-serial restoring reduction of a product modulo a modulus
module mod_reduce_seq #(
  parameter int PROD_W = rsa_pkg::PROD_W,
  parameter int MOD_W  = rsa_pkg::MOD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PROD_W-1:0] product,
  input  logic [MOD_W-1:0]  modulus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MOD_W-1:0]  result
);

  import rsa_pkg::*;

  localparam int CNT_W = $clog2(PROD_W);

  red_state_t        state_q, state_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic [MOD_W-1:0]  m_q, m_d;
  // The partial remainder stays below the modulus after every step, so its
  // MOD_W+1-th bit is always zero and is not stored.
  logic [MOD_W-1:0]  r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [MOD_W-1:0]  result_q, result_d;

  logic [MOD_W:0]    t_cur;
  logic [MOD_W-1:0]  t_next;

  // Shift the next product bit (MSB first) into the partial remainder.
  assign t_cur = {r_q, p_q[PROD_W-1]};

  cond_sub #(
    .W(MOD_W + 1)
  ) u_cond_sub (
    .t      (t_cur),
    .m      ({1'b0, m_q}),
    .t_next (t_next)
  );

  // State and datapath registers; reset aborts any reduction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      p_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_q      <= m_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Next-state logic: accept in IDLE, one product bit per RUN cycle, one DONE cycle.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d   = product;
          m_d   = modulus;
          r_d   = '0;
          cnt_d = CNT_W'(PROD_W - 1);
          err_d = 1'b0;
          if (modulus == '0) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = t_next;
        p_d   = {p_q[PROD_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          result_d = t_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb/tb_mod_reduce_seq.sv - scoreboard bench for mod_reduce_seq
module tb_mod_reduce_seq;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [127:0]  product;
  logic [63:0]   modulus;
  logic          busy;
  logic          done;
  logic          err;
  logic [63:0]   result;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          lat;
    int          cyc0;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  mod_reduce_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .product (product),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_width", {127'd0, prev_done}, 128'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 128'd1, 128'd0);
      end else begin
        popped = sb.pop_front();
        chk("result", {64'd0, result}, {64'd0, popped.res});
        chk("err", {127'd0, err}, {127'd0, popped.err});
        chk("latency", 128'(cyc - popped.cyc0), 128'(popped.lat));
      end
    end
    prev_done = (done === 1'b1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one start, push its expectation, and wait for completion.
  // ign_at/rst_at (0 = off) inject an ignored start or a reset at cycle t+N.
  task automatic send(input logic [127:0] prod, input logic [63:0] md,
                      input bit chk_busy, input int ign_at, input int rst_at);
    exp_t x;
    logic [127:0] ref_mod;
    ref_mod = {64'd0, md};
    start   = 1'b1;
    product = prod;
    modulus = md;
    x.res   = (md == 64'd0) ? 64'd0 : 64'(prod % ref_mod);
    x.err   = (md == 64'd0);
    x.lat   = (md == 64'd0) ? 1 : 129;
    x.cyc0  = cyc;
    sb.push_back(x);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) begin
        start   = 1'b0;
        product = rnd128();
        modulus = {$urandom, $urandom};
      end
      if (chk_busy) begin
        if (md != 64'd0) begin
          if (i == 1 || i == 128 || i == 129) chk("busy", {127'd0, busy}, {127'd0, (i <= 128)});
          if (i == 1) chk("err_clear", {127'd0, err}, 128'd0);
        end else if (i == 1) begin
          chk("busy_zero_mod", {127'd0, busy}, 128'd0);
        end
      end
      if (ign_at != 0 && i == ign_at) begin
        start   = 1'b1;
        product = rnd128();
        modulus = 64'd12345;
      end
      if (ign_at != 0 && i == ign_at + 1) start = 1'b0;
      if (rst_at != 0 && i == rst_at) begin
        reset = 1'b1;
        sb.delete();
      end
      if (rst_at != 0 && i == rst_at + 1) begin
        reset = 1'b0;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_result", {64'd0, result}, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
      end
      if (sb.size() == 0 && (rst_at == 0 || i > rst_at + 1)) break;
    end
    if (sb.size() != 0) begin
      chk("timeout", 128'd1, 128'd0);
      sb.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] p;
    logic [63:0]  m;
    reset   = 1'b1;
    start   = 1'b0;
    product = '0;
    modulus = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_result", {64'd0, result}, 128'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("idle_busy", {127'd0, busy}, 128'd0);
    chk("idle_done", {127'd0, done}, 128'd0);
    chk("idle_err", {127'd0, err}, 128'd0);
    chk("idle_result", {64'd0, result}, 128'd0);

    send(128'd323, 64'd7, 1'b1, 0, 0);
    send({128{1'b1}}, {64{1'b1}}, 1'b0, 0, 0);
    send(128'd5, 64'd9, 1'b0, 0, 0);
    p = 128'd1 << 127;
    send(p, 64'd3, 1'b0, 0, 0);
    send(rnd128(), 64'd0, 1'b1, 0, 0);
    send(128'd1000, 64'd33, 1'b1, 0, 0);
    send(rnd128(), 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 10, 0);
    send(rnd128(), 64'h1234_5678_9ABC_DEF1, 1'b0, 0, 50);
    repeat (140) @(negedge clk);
    #1;
    chk("post_abort_busy", {127'd0, busy}, 128'd0);

    reset   = 1'b1;
    start   = 1'b1;
    product = 128'd77;
    modulus = 64'd5;
    @(negedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {127'd0, busy}, 128'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_start_idle", {127'd0, busy}, 128'd0);

    send(rnd128(), 64'hFEDC_BA98_7654_3211, 1'b1, 0, 0);
    send(rnd128(), 64'd1, 1'b0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      p = rnd128();
      m = {$urandom, $urandom};
      if (k % 5 == 1) m = 64'($urandom_range(1, 1000));
      if (k % 5 == 3) p = {64'd0, m >> 1};
      if (k == 7)     m = 64'd0;
      send(p, m, 1'b0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
